// File: rtl/keypad_event_ctrl.sv
// Keypad event sequencer: synchronizes the scanner's key level and code, qualifies presses
// and releases, generates auto-repeat events and queues them in a small FWFT FIFO.
module keypad_event_ctrl #(
    parameter int STABLE_CYC  = 64,
    parameter int REPEAT_DLY  = 1000000,
    parameter int REPEAT_RATE = 200000,
    parameter int FIFO_DEPTH  = 4,
    parameter int CNT_W       = 24
) (
    input  logic                          sys_clk,
    input  logic                          rst,
    input  logic                          key_down,
    input  logic [3:0]                    key_code,
    input  logic                          rep_en,
    input  logic                          evt_ready,
    input  logic                          clr_ovf,
    output logic                          evt_valid,
    output logic [3:0]                    evt_code,
    output logic                          evt_repeat,
    output logic [$clog2(FIFO_DEPTH):0]   evt_count,
    output logic                          overflow
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] DLY_LOAD    = CNT_W'(REPEAT_DLY - 1);
    localparam logic [CNT_W-1:0] RATE_LOAD   = CNT_W'(REPEAT_RATE - 1);
    localparam logic [PTR_W:0]   DEPTH_V     = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, QUAL, HELD, RPT} state_t;

    typedef struct packed {
        logic [3:0] code;
        logic       is_repeat;
    } event_t;

    logic [1:0]       down_sync;
    logic [3:0]       code_sync1;
    logic [3:0]       code_s;
    logic             down_s;

    state_t           state;
    logic [CNT_W-1:0] stab_cnt;
    logic [CNT_W-1:0] rel_cnt;
    logic [CNT_W-1:0] timer;
    logic [3:0]       held_code;

    logic             push;
    event_t           push_evt;

    event_t           mem [FIFO_DEPTH];
    event_t           head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_nxt;
    logic             pop;
    logic             full;
    logic             do_write;
    logic             drop;

    // The code bus is only sampled after a full qualification window, so a plain 2-flop
    // synchronizer per bit is safe: the scanner holds it stable while key_down is high.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            down_sync  <= '0;
            code_sync1 <= '0;
            code_s     <= '0;
        end else begin
            down_sync  <= {down_sync[0], key_down};
            code_sync1 <= key_code;
            code_s     <= code_sync1;
        end
    end

    assign down_s = down_sync[1];

    always_comb begin
        push               = 1'b0;
        push_evt.code      = held_code;
        push_evt.is_repeat = 1'b1;
        case (state)
            QUAL: begin
                if (down_s && stab_cnt == STABLE_LAST) begin
                    push               = 1'b1;
                    push_evt.code      = code_s;
                    push_evt.is_repeat = 1'b0;
                end
            end
            HELD, RPT: begin
                // A low level freezes the repeat timer and suppresses pushes.
                if (down_s && timer == '0 && rep_en) begin
                    push = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            stab_cnt  <= '0;
            rel_cnt   <= '0;
            timer     <= '0;
            held_code <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (down_s) begin
                        stab_cnt <= '0;
                        state    <= QUAL;
                    end
                end
                QUAL: begin
                    if (!down_s) begin
                        state <= IDLE;
                    end else if (stab_cnt == STABLE_LAST) begin
                        held_code <= code_s;
                        timer     <= DLY_LOAD;
                        rel_cnt   <= '0;
                        state     <= HELD;
                    end else begin
                        stab_cnt <= stab_cnt + 1'b1;
                    end
                end
                HELD, RPT: begin
                    if (!down_s) begin
                        if (rel_cnt == STABLE_LAST) begin
                            state <= IDLE;
                        end else begin
                            rel_cnt <= rel_cnt + 1'b1;
                        end
                    end else begin
                        rel_cnt <= '0;
                        if (timer != '0) begin
                            timer <= timer - 1'b1;
                        end else if (rep_en) begin
                            timer <= RATE_LOAD;
                            state <= RPT;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pop      = evt_valid && evt_ready;
    assign full     = (count == DEPTH_V);
    assign do_write = push && (!full || pop);
    assign drop     = push && full && !pop;

    always_comb begin
        count_nxt = count;
        if (do_write && !pop) begin
            count_nxt = count + 1'b1;
        end else if (pop && !do_write) begin
            count_nxt = count - 1'b1;
        end
    end

    // NOTE: the storage array has no reset; the head outputs are masked by evt_valid instead.
    always_ff @(posedge sys_clk) begin
        if (do_write) begin
            mem[wr_ptr] <= push_evt;
        end
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            evt_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count     <= count_nxt;
            evt_valid <= (count_nxt != '0);
            // A drop in the same cycle as clr_ovf keeps the flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    assign head       = mem[rd_ptr];
    assign evt_code   = evt_valid ? head.code : 4'h0;
    assign evt_repeat = evt_valid ? head.is_repeat : 1'b0;
    assign evt_count  = count;

endmodule
